datapath_sequencer: RTL and testbench
=====================================

// Module: datapath_sequencer
// PURPOSE
//  Control-side initiator for the register-file/ALU/memory datapath (circuit).
//  Accepts one micro-op per valid/ready handshake. Phases r1/r2/ALUc/memr/memw/regw over fixed cycles.
//  Every control output is registered and changes only on posedge clk, so no strobe moves with the edge it is sampled on.
//  Returns the datapath dout on a response handshake.
// PARAMETERS
//  ADDR_W         5   register address width (r1, r2)
//  ALUC_W         5   ALU control width
//  DATA_W         32  datapath data width (dout, rsp_data)
//  ACCESS_CYCLES  1   cycles spent in ACCESS (>=1); values <1 are treated as 1
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  reset      in   1       synchronous, active-high
//  req_valid  in   1       micro-op present
//  req_ready  out  1       sequencer can accept (IDLE only)
//  req_op     in   2       00 NOP, 01 ALU, 10 LOAD, 11 STORE
//  req_r1     in   ADDR_W  source register select
//  req_r2     in   ADDR_W  second source / write-back destination
//  req_aluc   in   ALUC_W  ALU function for ALU op
//  r1         out  ADDR_W  to datapath r1
//  r2         out  ADDR_W  to datapath r2
//  ALUc       out  ALUC_W  to datapath ALU control
//  regw       out  1       register write strobe
//  memw       out  1       memory write strobe
//  memr       out  1       memory read enable
//  dout       in   DATA_W  datapath result/read data
//  rsp_valid  out  1       result available
//  rsp_ready  in   1       consumer takes result
//  rsp_data   out  DATA_W  captured dout
// BEHAVIOUR
//  Reset (sync, high): state=IDLE, all outputs 0 except req_ready=1, ACCESS counter=0.
//   This takes priority over every other event.
//  States: IDLE, SETUP, ACCESS, WB, RESP.
//  Accept: req_valid && req_ready at posedge k. Capture op, r1, r2, aluc.
//  State transitions:
//   - NOP goes IDLE -> RESP and presents rsp_valid in cycle k+1.
//   - All other ops go IDLE -> SETUP.
//  SETUP (1 cycle):
//   - r1/r2/ALUc driven from captured fields; they hold until return to IDLE.
//   - ALUc=0 for LOAD/STORE.
//   - regw/memr/memw stay 0. Next state: ACCESS.
//  ACCESS (ACCESS_CYCLES cycles):
//   - memr=1 for LOAD; memw=1 for STORE; neither for ALU.
//   - Next state after the last cycle: WB for ALU/LOAD, RESP for STORE.
//   - memw deasserts on entry to RESP.
//  WB (1 cycle):
//   - regw=1 for exactly this cycle; r1/r2/ALUc unchanged; memr held for LOAD.
//   - dout is sampled into rsp_data at the posedge leaving WB. Next state: RESP.
//   - STORE captures dout at the posedge leaving ACCESS.
//  RESP:
//   - rsp_valid=1 and rsp_data stable until rsp_valid && rsp_ready.
//   - On that handshake: state goes to IDLE; rsp_valid, r1, r2 and ALUc clear to 0; req_ready=1 next cycle.
//  Handshakes:
//   - req_ready=1 only in IDLE. No new request is accepted in the same cycle a response completes.
//   - rsp_ready is ignored outside RESP.
//  Latency with ACCESS_CYCLES=1: rsp_valid first at k+4 (ALU/LOAD), k+3 (STORE), k+1 (NOP).
//  Exclusivity: regw, memw and memr are never asserted in the same cycle as a change of r1/r2/ALUc.
//   regw and memw are mutually exclusive.
//  Reset mid-operation: the in-flight op is dropped. No regw/memw is issued after the reset edge and no response is produced.
//  Illegal req_op values: none exist (2-bit encoding is fully used).
// TESTING
//  - Reset: reset=1 for 2 cycles, then 0 -> req_ready=1; r1=r2=ALUc=0; regw=memw=memr=rsp_valid=0.
//  - ALU: op=01, r1=0, r2=1, aluc=5'h02, dout=32'd7, rsp_ready=1 ->
//    SETUP at k+1 with r1=0, r2=1; regw=1 only at k+3; rsp_valid=1 at k+4 with rsp_data=7.
//  - LOAD: op=10, r1=3, r2=4, dout=32'hDEAD_BEEF ->
//    memr=1 over k+2..k+3; regw=1 at k+3 only; rsp_data=32'hDEAD_BEEF.
//  - STORE with ACCESS_CYCLES=3: op=11 ->
//    memw=1 for exactly k+2..k+4; regw never 1; rsp_valid at k+5.
//  - Backpressure: rsp_ready=0 for 5 cycles in RESP ->
//    rsp_valid and rsp_data held; req_ready=0; a pending req_valid is not accepted until one cycle after the handshake.
//  - Reset mid-op: assert reset during WB of an ALU op ->
//    regw=0 from the next cycle; no rsp_valid; req_ready=1 after reset is released.

Source files
------------

// File: rtl/datapath_sequencer_if.sv
// Micro-op request/response and datapath control bundle for datapath_sequencer.
// The sequencer takes the master view and the datapath/requester side takes the slave view.
interface datapath_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int ALUC_W = 5,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_r1;
  logic [ADDR_W-1:0] req_r2;
  logic [ALUC_W-1:0] req_aluc;

  logic [ADDR_W-1:0] r1;
  logic [ADDR_W-1:0] r2;
  logic [ALUC_W-1:0] ALUc;
  logic              regw;
  logic              memw;
  logic              memr;
  logic [DATA_W-1:0] dout;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    input  req_valid, req_op, req_r1, req_r2, req_aluc, dout, rsp_ready,
    output req_ready, r1, r2, ALUc, regw, memw, memr, rsp_valid, rsp_data
  );

  modport slave (
    output req_valid, req_op, req_r1, req_r2, req_aluc, dout, rsp_ready,
    input  req_ready, r1, r2, ALUc, regw, memw, memr, rsp_valid, rsp_data
  );
endinterface

// File: rtl/datapath_sequencer.sv
// Control-side initiator: one micro-op per request handshake, stepped through
// SETUP/ACCESS/WB/RESP with every datapath control output registered.
module datapath_sequencer #(
  parameter int ADDR_W        = 5,
  parameter int ALUC_W        = 5,
  parameter int DATA_W        = 32,
  parameter int ACCESS_CYCLES = 1
) (
  input logic                 clk,
  input logic                 reset,
  datapath_sequencer_if.master bus
);

  localparam int unsigned ACC   = (ACCESS_CYCLES < 1) ? 1 : ACCESS_CYCLES;
  localparam int unsigned CNT_W = (ACC > 1) ? $clog2(ACC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WB, RESP} state_t;
  typedef enum logic [1:0] {OP_NOP, OP_ALU, OP_LOAD, OP_STORE} op_t;

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] r1_q, r1_d;
  logic [ADDR_W-1:0] r2_q, r2_d;
  logic [ALUC_W-1:0] aluc_q, aluc_d;
  logic              regw_q, regw_d;
  logic              memw_q, memw_d;
  logic              memr_q, memr_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_NOP;
      cnt_q       <= '0;
      r1_q        <= '0;
      r2_q        <= '0;
      aluc_q      <= '0;
      regw_q      <= 1'b0;
      memw_q      <= 1'b0;
      memr_q      <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      r1_q        <= r1_d;
      r2_q        <= r2_d;
      aluc_q      <= aluc_d;
      regw_q      <= regw_d;
      memw_q      <= memw_d;
      memr_q      <= memr_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Outputs are computed one cycle ahead from the next-state decision so that
  // each strobe is a plain flop and never shares a cycle with a select change.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    r1_d        = r1_q;
    r2_d        = r2_q;
    aluc_d      = aluc_q;
    regw_d      = regw_q;
    memw_d      = memw_q;
    memr_d      = memr_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          op_d        = op_t'(bus.req_op);
          req_ready_d = 1'b0;
          if (op_t'(bus.req_op) == OP_NOP) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = '0;
          end else begin
            state_d = SETUP;
            r1_d    = bus.req_r1;
            r2_d    = bus.req_r2;
            aluc_d  = (op_t'(bus.req_op) == OP_ALU) ? bus.req_aluc : '0;
          end
        end
      end

      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
        memr_d  = (op_q == OP_LOAD);
        memw_d  = (op_q == OP_STORE);
      end

      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          if (op_q == OP_STORE) begin
            state_d     = RESP;
            memw_d      = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = bus.dout;
          end else begin
            state_d = WB;
            regw_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WB: begin
        state_d     = RESP;
        regw_d      = 1'b0;
        memr_d      = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_data_d  = bus.dout;
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          r1_d        = '0;
          r2_d        = '0;
          aluc_d      = '0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        regw_d      = 1'b0;
        memw_d      = 1'b0;
        memr_d      = 1'b0;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  assign bus.req_ready = req_ready_q;
  assign bus.r1        = r1_q;
  assign bus.r2        = r2_q;
  assign bus.ALUc      = aluc_q;
  assign bus.regw      = regw_q;
  assign bus.memw      = memw_q;
  assign bus.memr      = memr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  a_regw_memw_excl: assert property (@(posedge clk) disable iff (reset)
    !(regw_q && memw_q));

  a_memr_memw_excl: assert property (@(posedge clk) disable iff (reset)
    !(memr_q && memw_q));

  a_no_strobe_on_sel_change: assert property (@(posedge clk) disable iff (reset)
    ((r1_q != $past(r1_q)) || (r2_q != $past(r2_q)) || (aluc_q != $past(aluc_q)))
      |-> !(regw_q || memw_q || memr_q));

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: one instance with a single ACCESS cycle
// and one with three, driven on negedges and sampled on negedges.
module tb_datapath_sequencer;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  datapath_sequencer_if #(.ADDR_W(5), .ALUC_W(5), .DATA_W(32)) bus1 ();
  datapath_sequencer_if #(.ADDR_W(5), .ALUC_W(5), .DATA_W(32)) bus3 ();

  datapath_sequencer #(.ADDR_W(5), .ALUC_W(5), .DATA_W(32), .ACCESS_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  datapath_sequencer #(.ADDR_W(5), .ALUC_W(5), .DATA_W(32), .ACCESS_CYCLES(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Runs one op on the single-ACCESS-cycle instance with rsp_ready held high.
  // dout carries the real value only in the cycle whose closing edge captures it.
  task automatic do_op(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] fn, input logic [31:0] data);
    int         rsp_j;
    logic       in_op;
    logic [4:0] exp_alu;
    rsp_j   = (op == 2'b00) ? 1 : (op == 2'b11) ? 3 : 4;
    exp_alu = (op == 2'b01) ? fn : 5'd0;
    @(negedge clk);
    bus1.req_valid = 1'b1;
    bus1.req_op    = op;
    bus1.req_r1    = a;
    bus1.req_r2    = b;
    bus1.req_aluc  = fn;
    bus1.rsp_ready = 1'b1;
    bus1.dout      = ~data;
    chk("accept_ready", {31'd0, bus1.req_ready}, 32'd1);
    @(posedge clk);
    for (int j = 1; j <= rsp_j + 1; j++) begin
      @(negedge clk);
      bus1.req_valid = 1'b0;
      in_op = (op != 2'b00) && (j <= rsp_j);
      chk("r1",        {27'd0, bus1.r1},   in_op ? {27'd0, a} : 32'd0);
      chk("r2",        {27'd0, bus1.r2},   in_op ? {27'd0, b} : 32'd0);
      chk("aluc",      {27'd0, bus1.ALUc}, in_op ? {27'd0, exp_alu} : 32'd0);
      chk("regw",      {31'd0, bus1.regw}, ((op == 2'b01 || op == 2'b10) && j == 3) ? 32'd1 : 32'd0);
      chk("memr",      {31'd0, bus1.memr}, (op == 2'b10 && (j == 2 || j == 3)) ? 32'd1 : 32'd0);
      chk("memw",      {31'd0, bus1.memw}, (op == 2'b11 && j == 2) ? 32'd1 : 32'd0);
      chk("rsp_valid", {31'd0, bus1.rsp_valid}, (j == rsp_j) ? 32'd1 : 32'd0);
      chk("req_ready", {31'd0, bus1.req_ready}, (j == rsp_j + 1) ? 32'd1 : 32'd0);
      if (j == rsp_j && op != 2'b00)
        chk("rsp_data", bus1.rsp_data, data);
      bus1.dout = (j == rsp_j - 1) ? data : ~data;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_op = 2'b00; bus1.req_r1 = '0; bus1.req_r2 = '0;
    bus1.req_aluc = '0; bus1.dout = '0; bus1.rsp_ready = 1'b0;
    bus3.req_valid = 1'b0; bus3.req_op = 2'b00; bus3.req_r1 = '0; bus3.req_r2 = '0;
    bus3.req_aluc = '0; bus3.dout = '0; bus3.rsp_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus1.req_ready}, 32'd1);
    chk("rst_r1",        {27'd0, bus1.r1},   32'd0);
    chk("rst_r2",        {27'd0, bus1.r2},   32'd0);
    chk("rst_aluc",      {27'd0, bus1.ALUc}, 32'd0);
    chk("rst_regw",      {31'd0, bus1.regw}, 32'd0);
    chk("rst_memw",      {31'd0, bus1.memw}, 32'd0);
    chk("rst_memr",      {31'd0, bus1.memr}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    chk("rst3_req_ready", {31'd0, bus3.req_ready}, 32'd1);

    // Main function on the single-cycle-ACCESS instance
    do_op(2'b01, 5'd0,  5'd1,  5'h02, 32'd7);
    do_op(2'b10, 5'd3,  5'd4,  5'h1F, 32'hDEAD_BEEF);
    do_op(2'b11, 5'd10, 5'd17, 5'h0A, 32'h1234_5678);
    do_op(2'b00, 5'd5,  5'd6,  5'h07, 32'h0);
    do_op(2'b01, 5'd31, 5'd30, 5'h15, 32'hFFFF_FFFF);

    // STORE with three ACCESS cycles
    @(negedge clk);
    bus3.req_valid = 1'b1; bus3.req_op = 2'b11; bus3.req_r1 = 5'd7; bus3.req_r2 = 5'd9;
    bus3.req_aluc = 5'h0C; bus3.rsp_ready = 1'b1; bus3.dout = 32'h0BAD_0BAD;
    @(posedge clk);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      bus3.req_valid = 1'b0;
      chk("st3_memw",      {31'd0, bus3.memw}, (j >= 2 && j <= 4) ? 32'd1 : 32'd0);
      chk("st3_regw",      {31'd0, bus3.regw}, 32'd0);
      chk("st3_memr",      {31'd0, bus3.memr}, 32'd0);
      chk("st3_rsp_valid", {31'd0, bus3.rsp_valid}, (j == 5) ? 32'd1 : 32'd0);
      chk("st3_req_ready", {31'd0, bus3.req_ready}, (j == 6) ? 32'd1 : 32'd0);
      chk("st3_r2",        {27'd0, bus3.r2},   (j <= 5) ? 32'd9 : 32'd0);
      chk("st3_aluc",      {27'd0, bus3.ALUc}, 32'd0);
      if (j == 5) chk("st3_rsp_data", bus3.rsp_data, 32'hC0FF_EE00);
      bus3.dout = (j == 4) ? 32'hC0FF_EE00 : 32'h0BAD_0BAD;
    end

    // Backpressure in RESP with a request waiting behind it
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_op = 2'b01; bus1.req_r1 = 5'd2; bus1.req_r2 = 5'd6;
    bus1.req_aluc = 5'h03; bus1.rsp_ready = 1'b0; bus1.dout = 32'h5555_5555;
    @(posedge clk);
    @(negedge clk); bus1.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); bus1.dout = 32'hA5A5_0042;
    @(negedge clk); bus1.dout = 32'h5555_5555;
    chk("bp_rsp_valid0", {31'd0, bus1.rsp_valid}, 32'd1);
    chk("bp_rsp_data0",  bus1.rsp_data, 32'hA5A5_0042);
    bus1.req_valid = 1'b1; bus1.req_op = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd1);
      chk("bp_rsp_data",  bus1.rsp_data, 32'hA5A5_0042);
      chk("bp_req_ready", {31'd0, bus1.req_ready}, 32'd0);
      chk("bp_r2",        {27'd0, bus1.r2}, 32'd6);
    end
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    chk("bp_hs_req_ready", {31'd0, bus1.req_ready}, 32'd1);
    chk("bp_hs_r2",        {27'd0, bus1.r2}, 32'd0);
    @(negedge clk);
    bus1.req_valid = 1'b0;
    chk("bp_nop_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd1);
    chk("bp_nop_req_ready", {31'd0, bus1.req_ready}, 32'd0);
    @(negedge clk);
    chk("bp_end_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    chk("bp_end_req_ready", {31'd0, bus1.req_ready}, 32'd1);

    // Reset during WB of an ALU op
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_op = 2'b01; bus1.req_r1 = 5'd8; bus1.req_r2 = 5'd12;
    bus1.req_aluc = 5'h04; bus1.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); bus1.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rm_regw_wb", {31'd0, bus1.regw}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("rm_regw",      {31'd0, bus1.regw}, 32'd0);
    chk("rm_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
    chk("rm_r2",        {27'd0, bus1.r2}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rm_post_regw",      {31'd0, bus1.regw}, 32'd0);
      chk("rm_post_rsp_valid", {31'd0, bus1.rsp_valid}, 32'd0);
      chk("rm_post_req_ready", {31'd0, bus1.req_ready}, 32'd1);
    end

    // The sequencer still works after the aborted op
    do_op(2'b10, 5'd1, 5'd2, 5'h00, 32'h0000_00A5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
